sot_align_sequencer: RTL

Sequences start-of-frame alignment across NUM_LINKS TMR trigger-link frame aligners.
- Pulses one aligner reset at a time.
- Waits for that link's aligned flag, retries on timeout, then declares the link locked or failed.
- Re-queues locked links that lose alignment, using a round-robin scheduler over pending links.
- Sits between the trigger-link aligner array and slow control; all_ready_o gates the downstream cluster finder.

---
 rtl/sot_align_sequencer_pkg.sv | 6 +
 rtl/sot_align_sequencer_if.sv | 29 ++
 rtl/sot_align_sequencer_rr_pending_picker.sv | 20 ++
 rtl/sot_align_sequencer.sv | 125 ++++++++++++
 4 files changed

// File: rtl/sot_align_sequencer_pkg.sv
// sot_align_sequencer_pkg: shared constants (default link count, link index width) and the sequencer FSM encoding
package sot_align_sequencer_pkg;
  localparam int NUM_LINKS = 24;
  localparam int LINK_IDX_BITS = 5;
  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_PULSE, ST_WAIT} state_t;
endpackage

// File: rtl/sot_align_sequencer_if.sv
// sot_align_sequencer_if: slow-control and aligner-array bundle; slave modport = sequencer side, master modport = driver side
interface sot_align_sequencer_if import sot_align_sequencer_pkg::*; #(
  parameter int NUM_LINKS = sot_align_sequencer_pkg::NUM_LINKS,
  parameter int CNT_BITS = 8
);
  logic enable_i;
  logic [NUM_LINKS-1:0] mask_i;
  logic resync_i;
  logic cnt_reset_i;
  logic [15:0] timeout_i;
  logic [3:0] max_retries_i;
  logic [NUM_LINKS-1:0] sot_is_aligned_i;
  logic [NUM_LINKS-1:0] sot_unstable_i;
  logic [NUM_LINKS-1:0] aligner_reset_o;
  logic [NUM_LINKS-1:0] link_locked_o;
  logic [NUM_LINKS-1:0] link_failed_o;
  logic [NUM_LINKS*CNT_BITS-1:0] unstable_cnt_o;
  logic [LINK_IDX_BITS-1:0] current_link_o;
  logic busy_o;
  logic all_ready_o;
  modport slave (
    input enable_i, mask_i, resync_i, cnt_reset_i, timeout_i, max_retries_i, sot_is_aligned_i, sot_unstable_i,
    output aligner_reset_o, link_locked_o, link_failed_o, unstable_cnt_o, current_link_o, busy_o, all_ready_o
  );
  modport master (
    output enable_i, mask_i, resync_i, cnt_reset_i, timeout_i, max_retries_i, sot_is_aligned_i, sot_unstable_i,
    input aligner_reset_o, link_locked_o, link_failed_o, unstable_cnt_o, current_link_o, busy_o, all_ready_o
  );
endinterface

// File: rtl/sot_align_sequencer_rr_pending_picker.sv
// sot_align_sequencer_rr_pending_picker: combinational round-robin search of pending (in) from last+1 (in), giving valid/idx (out)
module sot_align_sequencer_rr_pending_picker import sot_align_sequencer_pkg::*; #(
  parameter int N = sot_align_sequencer_pkg::NUM_LINKS
) (
  input  logic [N-1:0] pending,
  input  logic [LINK_IDX_BITS-1:0] last,
  output logic valid,
  output logic [LINK_IDX_BITS-1:0] idx
);
  logic [LINK_IDX_BITS-1:0] j;
  always_comb begin
    valid = |pending;
    idx = '0;
    j = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = LINK_IDX_BITS'((int'(last) + 1 + k) % N);
      if (pending[j]) idx = j;
    end
  end
endmodule

// File: rtl/sot_align_sequencer.sv
// sot_align_sequencer: round-robin SOF-alignment sequencer; clock/reset_n_i (sync, active-low) plus slave bus (controls, aligner flags in; resets, lock/fail, counters, status out)
module sot_align_sequencer import sot_align_sequencer_pkg::*; #(
  parameter int NUM_LINKS = sot_align_sequencer_pkg::NUM_LINKS,
  parameter int RESET_CYCLES = 4,
  parameter int CNT_BITS = 8
) (
  input logic clock,
  input logic reset_n_i,
  sot_align_sequencer_if.slave bus
);
  state_t state, nxt;
  logic [LINK_IDX_BITS-1:0] sel, sel_n, last, last_n, pick_idx, cur, cur_n;
  logic served, served_n, pick_v, busy, busy_n, ready, ready_n;
  logic [3:0] retry, retry_n;
  logic [15:0] pcnt, pcnt_n, wcnt, wcnt_n, tmo;
  logic [NUM_LINKS-1:0] pending, pending_n, locked, locked_n, failed, failed_n, areset, areset_n, lost;
  logic pulse_done, tmo_hit, success, active, select, wdone;
  assign tmo = bus.timeout_i == 16'd0 ? 16'd1 : bus.timeout_i;
  assign pulse_done = pcnt == 16'(RESET_CYCLES - 1);
  assign tmo_hit = {1'b0, wcnt} + 17'd1 >= {1'b0, tmo};
  assign success = bus.sot_is_aligned_i[sel] && !bus.sot_unstable_i[sel];
  assign active = state != ST_IDLE;
  sot_align_sequencer_rr_pending_picker #(.N(NUM_LINKS)) u_picker (
    .pending(pending),
    .last(served ? last : LINK_IDX_BITS'(NUM_LINKS - 1)),
    .valid(pick_v),
    .idx(pick_idx)
  );
  always_ff @(posedge clock)
    state <= !reset_n_i ? ST_IDLE : nxt;
  always_comb begin
    nxt = !bus.enable_i ? ST_IDLE
        : (!active || bus.resync_i) ? ST_SCAN
        : state == ST_SCAN ? (pick_v ? ST_PULSE : ST_SCAN)
        : bus.mask_i[sel] ? ST_SCAN
        : state == ST_PULSE ? (pulse_done ? ST_WAIT : ST_PULSE)
        : success ? ST_SCAN
        : !tmo_hit ? ST_WAIT
        : retry < bus.max_retries_i ? ST_PULSE : ST_SCAN;
  end
  always_comb begin
    select = state == ST_SCAN && nxt == ST_PULSE;
    wdone = state == ST_WAIT && nxt == ST_SCAN && !bus.resync_i && !bus.mask_i[sel];
    sel_n = select ? pick_idx : sel;
    last_n = select ? pick_idx : last;
    served_n = served | select;
    retry_n = select ? 4'd0 : (state == ST_WAIT && nxt == ST_PULSE) ? retry + 4'd1 : retry;
    pcnt_n = (state == ST_PULSE && nxt == ST_PULSE) ? pcnt + 16'd1 : 16'd0;
    wcnt_n = (state == ST_WAIT && nxt == ST_WAIT) ? wcnt + 16'd1 : 16'd0;
    lost = active ? locked & ~bus.sot_is_aligned_i : '0;
    pending_n = pending | lost;
    locked_n = locked & ~lost;
    failed_n = failed;
    if (select) begin
      pending_n[pick_idx] = 1'b0;
      locked_n[pick_idx] = 1'b0;
      failed_n[pick_idx] = 1'b0;
    end
    if (wdone && success) locked_n[sel] = 1'b1;
    if (wdone && !success) failed_n[sel] = 1'b1;
    if (!active || bus.resync_i) begin
      pending_n = ~bus.mask_i;
      locked_n = '0;
      failed_n = '0;
    end
    if (!bus.enable_i) begin
      pending_n = '0;
      locked_n = '0;
      failed_n = '0;
    end
    pending_n = pending_n & ~bus.mask_i;
    locked_n = locked_n & ~bus.mask_i;
    failed_n = failed_n & ~bus.mask_i;
    busy_n = nxt == ST_PULSE || nxt == ST_WAIT;
    areset_n = nxt == ST_PULSE ? NUM_LINKS'(1) << sel_n : '0;
    cur_n = nxt == ST_IDLE ? '0 : sel_n;
    ready_n = bus.enable_i && nxt != ST_IDLE && &(locked_n | bus.mask_i) && !busy_n;
  end
  always_ff @(posedge clock)
    if (!reset_n_i) begin
      sel <= '0;
      last <= '0;
      served <= 1'b0;
      retry <= '0;
      pcnt <= '0;
      wcnt <= '0;
      pending <= '0;
      locked <= '0;
      failed <= '0;
      areset <= '0;
      busy <= 1'b0;
      cur <= '0;
      ready <= 1'b0;
    end else begin
      sel <= sel_n;
      last <= last_n;
      served <= served_n;
      retry <= retry_n;
      pcnt <= pcnt_n;
      wcnt <= wcnt_n;
      pending <= pending_n;
      locked <= locked_n;
      failed <= failed_n;
      areset <= areset_n;
      busy <= busy_n;
      cur <= cur_n;
      ready <= ready_n;
    end
  for (genvar i = 0; i < NUM_LINKS; i++) begin : g_cnt
    logic [CNT_BITS-1:0] c;
    logic q;
    always_ff @(posedge clock) begin
      q <= reset_n_i && bus.sot_unstable_i[i];
      if (!reset_n_i || bus.cnt_reset_i || bus.resync_i) c <= '0;
      else if (bus.sot_unstable_i[i] && !q && c != '1) c <= c + 1'b1;
    end
    assign bus.unstable_cnt_o[i*CNT_BITS +: CNT_BITS] = c;
  end
  assign bus.aligner_reset_o = areset;
  assign bus.link_locked_o = locked;
  assign bus.link_failed_o = failed;
  assign bus.current_link_o = cur;
  assign bus.busy_o = busy;
  assign bus.all_ready_o = ready;
endmodule
